// File: rtl/sumser_pkg.sv
// Shared constants, FSM state type and helpers for the multi-byte serial adder controller.
package sumser_pkg;

    localparam int BYTE_W = 8;
    localparam int TOG_W  = 16;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_RUN  = ST_RUN,
        S_DONE = ST_DONE
    } state_t;

    function automatic logic [3:0] popcount8(input logic [BYTE_W-1:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < BYTE_W; i++) begin
            n = n + {3'd0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/sumador_serial_ctrl_sum_rizado.sv
// SUM_RIZADO: 8-bit gate-level ripple-carry adder; PwrC selects the carry-gate form
// (propagate/generate vs. majority), which is functionally identical.
module SUM_RIZADO
    import sumser_pkg::*;
#(
    parameter int PwrC = 0
) (
    input  logic [BYTE_W-1:0] a,
    input  logic [BYTE_W-1:0] b,
    input  logic              ci,
    output logic [BYTE_W-1:0] s,
    output logic              co
);

    logic [BYTE_W:0] c;

    assign c[0] = ci;

    for (genvar i = 0; i < BYTE_W; i++) begin : g_bit
        assign s[i] = a[i] ^ b[i] ^ c[i];
        if (PwrC == 0) begin : g_prop
            assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end else begin : g_maj
            assign c[i+1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
        end
    end

    assign co = c[BYTE_W];

endmodule

// File: rtl/sumador_serial_ctrl.sv
// Multi-byte serial adder controller: one byte per cycle through SUM_RIZADO, LSB first.
// Optional sum-register toggle counter enabled by macro SUMADOR_SERIAL_PWR_CNT_EN.
module sumador_serial_ctrl
    import sumser_pkg::*;
#(
    parameter int NBYTES = 4,
    parameter int PwrC   = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [8*NBYTES-1:0]      in_a,
    input  logic [8*NBYTES-1:0]      in_b,
    input  logic                     in_ci,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [8*NBYTES-1:0]      out_sum,
    output logic                     out_co,
    output logic                     out_ovf,
    output logic [15:0]              pwr_toggles
);

    localparam int W     = BYTE_W * NBYTES;
    localparam int IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

    state_t             state_q, state_d;
    logic [W-1:0]       a_q, a_d;
    logic [W-1:0]       b_q, b_d;
    logic [W-1:0]       s_q, s_d;
    logic               carry_q, carry_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               co_q, co_d;
    logic               ovf_q, ovf_d;

    logic [BYTE_W-1:0]  a_byte, b_byte, s_byte_old, add_s;
    logic               add_co;

    assign a_byte     = a_q[idx_q*BYTE_W +: BYTE_W];
    assign b_byte     = b_q[idx_q*BYTE_W +: BYTE_W];
    assign s_byte_old = s_q[idx_q*BYTE_W +: BYTE_W];

    SUM_RIZADO #(.PwrC(PwrC)) u_sum (
        .a  (a_byte),
        .b  (b_byte),
        .ci (carry_q),
        .s  (add_s),
        .co (add_co)
    );

`ifdef SUMADOR_SERIAL_PWR_CNT_EN
    logic [TOG_W-1:0] tog_q, tog_d;

    always_comb begin
        tog_d = tog_q;
        if (state_q == S_RUN) begin
            tog_d = tog_q + TOG_W'(popcount8(add_s ^ s_byte_old));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) tog_q <= '0;
        else       tog_q <= tog_d;
    end

    assign pwr_toggles = tog_q;
`else
    logic unused_old_byte;
    assign unused_old_byte = ^s_byte_old;
    assign pwr_toggles     = 16'd0;
`endif

    always_comb begin
        // NOTE: every _d defaults to its _q first so no path leaves a latch.
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        co_d    = co_q;
        ovf_d   = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d     = in_a;
                    b_d     = in_b;
                    carry_d = in_ci;
                    idx_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                s_d[idx_q*BYTE_W +: BYTE_W] = add_s;
                carry_d = add_co;
                if (idx_q == LAST_IDX) begin
                    co_d    = add_co;
                    ovf_d   = (a_byte[BYTE_W-1] == b_byte[BYTE_W-1]) &&
                              (add_s[BYTE_W-1] != a_byte[BYTE_W-1]);
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: operand and sum registers are reset too, since out_sum is observable from reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            co_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values.
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
            co_q    <= co_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign out_sum   = s_q;
    assign out_co    = co_q;
    assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_sumador_serial_ctrl.sv
// Directed bench for sumador_serial_ctrl (NBYTES=4): scoreboard of expected results,
// latency, DONE back-pressure, mid-op reset and toggle-counter checks.
module tb_sumador_serial_ctrl;

    localparam int NBYTES = 4;
    localparam int W      = 8 * NBYTES;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_a = '0;
    logic [W-1:0]  in_b = '0;
    logic          in_ci = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  out_sum;
    logic          out_co;
    logic          out_ovf;
    logic [15:0]   pwr_toggles;

    typedef struct {
        logic [W-1:0] sum;
        logic         co;
        logic         ovf;
        logic [15:0]  tog;
    } exp_t;

    exp_t          sb[$];
    exp_t          last_exp;
    int            n_checks = 0;
    int            n_fail   = 0;
    logic [W-1:0]  model_prev = '0;
    logic [15:0]   model_tog  = '0;

    sumador_serial_ctrl #(.NBYTES(NBYTES), .PwrC(0)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .in_b        (in_b),
        .in_ci       (in_ci),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_sum     (out_sum),
        .out_co      (out_co),
        .out_ovf     (out_ovf),
        .pwr_toggles (pwr_toggles)
    );

    always #50 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] exp_pwr();
`ifdef SUMADOR_SERIAL_PWR_CNT_EN
        return model_tog;
`else
        return 16'd0;
`endif
    endfunction

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
        logic [W:0] full;
        exp_t e;
        check("in_ready_idle", in_ready, 1'b1);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_ci    = ci;
        full     = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
        e.sum    = full[W-1:0];
        e.co     = full[W];
        e.ovf    = (a[W-1] == b[W-1]) && (full[W-1] != a[W-1]);
        model_tog  = model_tog + 16'($countones(model_prev ^ e.sum));
        model_prev = e.sum;
        e.tog    = model_tog;
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        check({tag, "_out_valid"}, out_valid, 1'b1);
        check({tag, "_latency"}, 64'(n), 64'(NBYTES));
        check({tag, "_sb_nonempty"}, 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
            last_exp = sb.pop_front();
            check({tag, "_sum"}, out_sum, last_exp.sum);
            check({tag, "_co"},  out_co,  last_exp.co);
            check({tag, "_ovf"}, out_ovf, last_exp.ovf);
            check({tag, "_pwr"}, pwr_toggles, exp_pwr());
        end
    endtask

    task automatic finish_op(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_valid_drop"}, out_valid, 1'b0);
        check({tag, "_ready_back"}, in_ready, 1'b1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        sb.delete();
        model_prev = '0;
        model_tog  = '0;
        @(negedge clk);
        check("rst_in_ready",  in_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_sum",   out_sum, '0);
        check("rst_out_co",    out_co, 1'b0);
        check("rst_out_ovf",   out_ovf, 1'b0);
        check("rst_pwr",       pwr_toggles, 16'd0);
        reset = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        do_reset();

        start_op(32'h0000_00FF, 32'h0000_0001, 1'b0);
        wait_done("t1");
        finish_op("t1");

        start_op(32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
        wait_done("t2");
        finish_op("t2");

        start_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
        wait_done("t3");
        finish_op("t3");

        // Back-pressure in DONE with new operands offered.
        start_op(32'h1234_5678, 32'h0FED_CBA9, 1'b1);
        wait_done("t4a");
        in_valid = 1'b1;
        in_a     = 32'hDEAD_BEEF;
        in_b     = 32'h0101_0101;
        in_ci    = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("t4_hold_valid", out_valid, 1'b1);
            check("t4_hold_ready", in_ready, 1'b0);
            check("t4_hold_sum",   out_sum, last_exp.sum);
            check("t4_hold_co",    out_co, last_exp.co);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("t4_idle_valid", out_valid, 1'b0);
        start_op(32'hDEAD_BEEF, 32'h0101_0101, 1'b0);
        wait_done("t4b");
        finish_op("t4b");

        // Reset while idx=2.
        start_op(32'h1111_1111, 32'h2222_2222, 1'b0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("t5_rst_valid", out_valid, 1'b0);
        check("t5_rst_ready", in_ready, 1'b1);
        check("t5_rst_sum",   out_sum, '0);
        sb.delete();
        model_prev = '0;
        model_tog  = '0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        start_op(32'd5, 32'd7, 1'b0);
        wait_done("t5");
        check("t5_sum_c", out_sum, 32'h0000_000C);
        finish_op("t5");

        // Toggle counter from a fresh reset.
        do_reset();
        start_op(32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        wait_done("t6a");
`ifdef SUMADOR_SERIAL_PWR_CNT_EN
        check("t6a_pwr32", pwr_toggles, 16'd32);
`else
        check("t6a_pwr0", pwr_toggles, 16'd0);
`endif
        finish_op("t6a");
        start_op(32'h0, 32'h0, 1'b0);
        wait_done("t6b");
`ifdef SUMADOR_SERIAL_PWR_CNT_EN
        check("t6b_pwr64", pwr_toggles, 16'd64);
`else
        check("t6b_pwr0", pwr_toggles, 16'd0);
`endif
        finish_op("t6b");

        for (int k = 0; k < 6; k++) begin
            start_op(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));
            wait_done("rnd");
            finish_op("rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
